// File: rtl/riscv_pkg.sv
// Shared RV32 constants, reset defaults and the fetch FSM state type.
// The FAULT state exists only when ALIGN_CHECK_EN is defined.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP          = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;
`else
  typedef enum logic [1:0] {BOOT, RUN} fetch_state_e;
`endif
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched {pc, instr} pair with a valid bit.
// A flush clears the valid bit and takes priority over a load.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN(/FAULT) control and IF/ID register.
// Define ALIGN_CHECK_EN to trap misaligned redirect targets into a sticky FAULT state.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] instr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o
`ifdef ALIGN_CHECK_EN
  ,
  output logic            fault_o
`endif
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target;
  logic            load, flush;

  assign pc_o   = pc_q;
  assign target = redirect_pc_i & ALIGN_MASK;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid_i) begin
          flush = 1'b1;
`ifdef ALIGN_CHECK_EN
          if (redirect_pc_i[1:0] != 2'b00) state_d = FAULT;
          else                             pc_d    = target;
`else
          pc_d = target;
`endif
        end else if (!out_valid_o || out_ready_i) begin
          load = 1'b1;
          pc_d = pc_q + XLEN'(4);
        end
      end
`ifdef ALIGN_CHECK_EN
      FAULT: flush = 1'b1;
`endif
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & ALIGN_MASK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef ALIGN_CHECK_EN
  assign fault_o = (state_q == FAULT);
`endif

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .in_pc    (pc_q),
    .in_instr (instr_i),
    .valid    (out_valid_o),
    .pc       (out_pc_o),
    .instr    (out_instr_o)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory word at address a is {~a[15:0], a[15:0]}.
// Inputs change and outputs are checked on the falling clock edge.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o, instr_i, redirect_pc_i, out_instr_o, out_pc_o;
  logic        redirect_valid_i, out_valid_o, out_ready_i;
`ifdef ALIGN_CHECK_EN
  logic        fault_o;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign instr_i = {~pc_o[15:0], pc_o[15:0]};

  fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_o             (pc_o),
    .instr_i          (instr_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_instr_o      (out_instr_o),
    .out_pc_o         (out_pc_o)
`ifdef ALIGN_CHECK_EN
    ,
    .fault_o          (fault_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic out_chk(input string tag, input logic v, input logic [31:0] opc,
                         input logic [31:0] oins, input logic [31:0] fpc);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
    if (v) begin
      chk({tag, ".out_pc"}, out_pc_o, opc);
      chk({tag, ".out_instr"}, out_instr_o, oins);
    end
    chk({tag, ".pc"}, pc_o, fpc);
  endtask

  initial begin
    rst_n = 1'b0; out_ready_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst.instr", out_instr_o, 32'h0000_0013);
    chk("rst.out_pc", out_pc_o, 32'h0);
    chk("rst.pc", pc_o, 32'h0);
    rst_n = 1'b1;

    @(negedge clk); out_chk("boot", 1'b0, 0, 0, 32'h0);
    @(negedge clk); out_chk("f0", 1'b1, 32'h0, 32'hFFFF_0000, 32'h4);
    @(negedge clk); out_chk("f4", 1'b1, 32'h4, 32'hFFFB_0004, 32'h8);
    @(negedge clk); out_chk("f8", 1'b1, 32'h8, 32'hFFF7_0008, 32'hC);
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_chk("stall", 1'b1, 32'h8, 32'hFFF7_0008, 32'hC);
    end
    out_ready_i = 1'b1;
    @(negedge clk); out_chk("resume12", 1'b1, 32'hC, 32'hFFF3_000C, 32'h10);

    // redirect together with a completed handshake
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    @(negedge clk); out_chk("redir.flush", 1'b0, 0, 0, 32'h100);
    redirect_valid_i = 1'b0;
    @(negedge clk); out_chk("redir.tgt", 1'b1, 32'h100, 32'hFEFF_0100, 32'h104);

    // redirect while stalled, target at the top of the address space
    out_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk); out_chk("wrap.flush", 1'b0, 0, 0, 32'hFFFF_FFFC);
    out_ready_i = 1'b1; redirect_valid_i = 1'b0;
    @(negedge clk); out_chk("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'h0003_FFFC, 32'h0);
    @(negedge clk); out_chk("wrap.zero", 1'b1, 32'h0, 32'hFFFF_0000, 32'h4);

    // misaligned redirect target
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    @(negedge clk);
    redirect_valid_i = 1'b0;
`ifdef ALIGN_CHECK_EN
    chk("mis.fault", {31'd0, fault_o}, 32'd1);
    out_chk("mis.flush", 1'b0, 0, 0, 32'h4);
    repeat (2) @(negedge clk);
    chk("mis.sticky", {31'd0, fault_o}, 32'd1);
    out_chk("mis.frozen", 1'b0, 0, 0, 32'h4);
`else
    out_chk("mis.flush", 1'b0, 0, 0, 32'h100);
    @(negedge clk); out_chk("mis.tgt", 1'b1, 32'h100, 32'hFEFF_0100, 32'h104);
    out_ready_i = 1'b0;
    @(negedge clk); out_chk("mis.stall", 1'b1, 32'h100, 32'hFEFF_0100, 32'h104);
`endif

    // asynchronous reset in the middle of a cycle
    out_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst.instr", out_instr_o, 32'h0000_0013);
    chk("arst.out_pc", out_pc_o, 32'h0);
    chk("arst.pc", pc_o, 32'h0);
`ifdef ALIGN_CHECK_EN
    chk("arst.fault", {31'd0, fault_o}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; out_ready_i = 1'b1;
    @(negedge clk); out_chk("reboot", 1'b0, 0, 0, 32'h0);
    @(negedge clk); out_chk("refetch0", 1'b1, 32'h0, 32'hFFFF_0000, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
